// File: rtl/vdp_io_pkg.sv
// rtl/vdp_io_pkg.sv - shared types and decode helper for the Z80-to-VDP I/O bridge
package vdp_io_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WREQ = 2'd1,
        RREQ = 2'd2
    } io_state_t;

    // One queued OUT: the full synchronised address (offset taken at issue) and its data byte.
    typedef struct packed {
        logic [7:0] adr;
        logic [7:0] data;
    } io_wr_t;

    // True when addr falls inside the 2^addr_w port window starting at base.
    function automatic logic port_hit(input logic [7:0] addr, input logic [7:0] base, input int addr_w);
        return (addr >> addr_w) == (base >> addr_w);
    endfunction

endpackage

// File: rtl/vdp_io_bridge_debounce.sv
// rtl/vdp_io_bridge_debounce.sv - consecutive-sample glitch filter for one bus strobe
module pin_debounce #(
    parameter int LEN = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    localparam int CW = (LEN > 2) ? $clog2(LEN) : 1;

    logic [CW-1:0] cnt;

    // Output follows the input only after LEN consecutive samples that disagree with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout <= 1'b1;
            cnt  <= '0;
        end else if (din == dout) begin
            cnt <= '0;
        end else if (cnt == CW'(LEN - 1)) begin
            dout <= din;
            cnt  <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/vdp_io_bridge.sv
// rtl/vdp_io_bridge.sv - Z80 I/O port window to VDP request bridge with write FIFO
module vdp_io_bridge
    import vdp_io_pkg::*;
#(
    parameter logic [7:0] IO_BASE    = 8'h98,
    parameter int         ADDR_W     = 2,
    parameter int         FILTER_LEN = 3,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        io_addr,
    input  logic              iorq_n,
    input  logic              rd_n,
    input  logic              wr_n,
    input  logic [7:0]        cd_in,
    output logic [7:0]        cd_out,
    output logic              cd_oe,
    output logic              cs_n,
    output logic              vdp_req,
    output logic              vdp_wrt,
    output logic [ADDR_W-1:0] vdp_adr,
    output logic [7:0]        vdp_dbo,
    input  logic              vdp_ack,
    input  logic [7:0]        vdp_dbi,
    output logic              overflow,
    input  logic              ovf_clr
);

    localparam int IDX_W = $clog2(FIFO_DEPTH);

    logic [2:0]        strb_s1, strb_s2;
    logic [7:0]        addr_s1, addr_s2, data_s1, data_s2;
    logic              iorq_db, rd_db, wr_db;
    logic              rd_f, wr_f, rd_f_q, wr_f_q;
    logic              rd_rise, wr_rise, rd_ev, wr_ev;
    logic              rd_pend;
    logic [ADDR_W-1:0] rd_adr;
    io_wr_t            fifo_mem [FIFO_DEPTH];
    logic [IDX_W:0]    wp, rp;
    logic [IDX_W-1:0]  rp_idx;
    logic              empty, full, push, pop, drop;
    io_state_t         state, state_next;
    logic              load_head, load_new, load_rd;

    // Raw bus-side decode: the Z80 sees chip select and drive enable with no clock delay.
    assign cs_n  = ~(port_hit(io_addr, IO_BASE, ADDR_W) & ~iorq_n);
    assign cd_oe = ~cs_n & ~rd_n;

    // VDP read data is prefetched, so the bus simply mirrors it one clock later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cd_out <= '0;
        else       cd_out <= vdp_dbi;
    end

    // Two-flop synchroniser for strobes, address and data onto the pixel clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            strb_s1 <= 3'b111;
            strb_s2 <= 3'b111;
            addr_s1 <= '0;
            addr_s2 <= '0;
            data_s1 <= '0;
            data_s2 <= '0;
        end else begin
            strb_s1 <= {iorq_n, rd_n, wr_n};
            strb_s2 <= strb_s1;
            addr_s1 <= io_addr;
            addr_s2 <= addr_s1;
            data_s1 <= cd_in;
            data_s2 <= data_s1;
        end
    end

    pin_debounce #(.LEN(FILTER_LEN)) u_iorq_db (.clk(clk), .reset(reset), .din(strb_s2[2]), .dout(iorq_db));
    pin_debounce #(.LEN(FILTER_LEN)) u_rd_db   (.clk(clk), .reset(reset), .din(strb_s2[1]), .dout(rd_db));
    pin_debounce #(.LEN(FILTER_LEN)) u_wr_db   (.clk(clk), .reset(reset), .din(strb_s2[0]), .dout(wr_db));

    assign rd_f    = port_hit(addr_s2, IO_BASE, ADDR_W) & ~iorq_db & ~rd_db;
    assign wr_f    = port_hit(addr_s2, IO_BASE, ADDR_W) & ~iorq_db & ~wr_db;
    assign rd_rise = rd_f & ~rd_f_q;
    assign wr_rise = wr_f & ~wr_f_q;
    // Both strobes rising together is not a legal Z80 cycle; neither is acted on.
    assign rd_ev   = rd_rise & ~wr_rise;
    assign wr_ev   = wr_rise & ~rd_rise;

    // Previous filtered levels; an event needs the strobe to drop before it can fire again.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_f_q <= 1'b0;
            wr_f_q <= 1'b0;
        end else begin
            rd_f_q <= rd_f;
            wr_f_q <= wr_f;
        end
    end

    assign rp_idx = rp[IDX_W-1:0];
    assign empty  = (wp == rp);
    assign full   = (wp[IDX_W] != rp[IDX_W]) && (wp[IDX_W-1:0] == rp[IDX_W-1:0]);
    assign pop    = (state == WREQ) & vdp_ack;
    assign push   = wr_ev & (~full | pop);
    assign drop   = wr_ev & full & ~pop;

    // FIFO storage; pointers alone define validity, so the array needs no reset.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wp[IDX_W-1:0]] <= io_wr_t'{adr: addr_s2, data: data_s2};
    end

    // FIFO pointers wrap naturally; the extra MSB separates full from empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop)  rp <= rp + 1'b1;
        end
    end

    // Pending read and its port offset; released only when the read is acknowledged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pend <= 1'b0;
            rd_adr  <= '0;
        end else if (rd_ev) begin
            rd_pend <= 1'b1;
            rd_adr  <= addr_s2[ADDR_W-1:0];
        end else if (state == RREQ && vdp_ack) begin
            rd_pend <= 1'b0;
        end
    end

    // Sticky overflow; a new drop outranks a clear in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        overflow <= 1'b0;
        else if (drop)    overflow <= 1'b1;
        else if (ovf_clr) overflow <= 1'b0;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next state: writes drain first, a pending read goes only once the FIFO is empty.
    // A push into an empty FIFO is issued straight from the incoming word to save a clock.
    always_comb begin
        state_next = state;
        load_head  = 1'b0;
        load_new   = 1'b0;
        load_rd    = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    state_next = WREQ;
                    load_head  = 1'b1;
                end else if (push) begin
                    state_next = WREQ;
                    load_new   = 1'b1;
                end else if (rd_pend || rd_ev) begin
                    state_next = RREQ;
                    load_rd    = 1'b1;
                end
            end
            WREQ:    if (vdp_ack) state_next = IDLE;
            RREQ:    if (vdp_ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request fields are loaded only on leaving IDLE, so they hold steady while vdp_req is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vdp_req <= 1'b0;
            vdp_wrt <= 1'b0;
            vdp_adr <= '0;
            vdp_dbo <= '0;
        end else begin
            vdp_req <= (state_next != IDLE);
            if (load_head) begin
                vdp_wrt <= 1'b1;
                vdp_adr <= fifo_mem[rp_idx].adr[ADDR_W-1:0];
                vdp_dbo <= fifo_mem[rp_idx].data;
            end else if (load_new) begin
                vdp_wrt <= 1'b1;
                vdp_adr <= addr_s2[ADDR_W-1:0];
                vdp_dbo <= data_s2;
            end else if (load_rd) begin
                vdp_wrt <= 1'b0;
                vdp_adr <= rd_ev ? addr_s2[ADDR_W-1:0] : rd_adr;
            end
        end
    end

endmodule

// File: tb/tb_vdp_io_bridge.sv
// tb/tb_vdp_io_bridge.sv - directed table-driven bench for vdp_io_bridge
module tb_vdp_io_bridge;

    localparam int FILTER_LEN = 3;
    localparam int LAT        = 2 + FILTER_LEN + 1;

    logic       clk, rst;
    logic [7:0] io_addr, cd_in, cd_out, vdp_dbo, vdp_dbi;
    logic       iorq_n, rd_n, wr_n, cd_oe, cs_n;
    logic       vdp_req, vdp_wrt, vdp_ack, overflow, ovf_clr;
    logic [1:0] vdp_adr;

    vdp_io_bridge #(.IO_BASE(8'h98), .ADDR_W(2), .FILTER_LEN(FILTER_LEN), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(rst), .io_addr(io_addr), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
        .cd_in(cd_in), .cd_out(cd_out), .cd_oe(cd_oe), .cs_n(cs_n),
        .vdp_req(vdp_req), .vdp_wrt(vdp_wrt), .vdp_adr(vdp_adr), .vdp_dbo(vdp_dbo),
        .vdp_ack(vdp_ack), .vdp_dbi(vdp_dbi), .overflow(overflow), .ovf_clr(ovf_clr)
    );

    typedef struct { bit wrt; logic [7:0] adr; logic [7:0] dbo; } ev_t;
    typedef struct { logic [7:0] addr; bit iorq; bit rd; bit exp_cs_n; bit exp_oe; } dv_t;
    typedef struct { logic [7:0] addr; logic [7:0] data; bit push; logic [7:0] adr; } wv_t;

    ev_t  log_q[$];
    dv_t  dtab[7];
    wv_t  wtab[7];
    int   n_cmp = 0, n_bad = 0;
    int   cyc = 0, req_rises = 0, rise_cyc = 0, fall_cyc = 0, last_gap = 0;
    int   ack_delay = 5, req_cnt = 0;
    bit   ack_en = 1;
    logic req_prev = 1'b0;
    logic [7:0] dbi_val = 8'h00;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Request monitor and VDP acknowledge model, both on the falling edge.
    initial forever begin
        ev_t e;
        @(negedge clk);
        if (vdp_req && !req_prev) begin
            req_rises++;
            last_gap = cyc - fall_cyc;
            rise_cyc = cyc;
        end
        if (!vdp_req && req_prev) fall_cyc = cyc;
        req_prev = vdp_req;
        vdp_ack = 1'b0;
        if (vdp_req && ack_en && !rst) begin
            req_cnt++;
            if (req_cnt >= ack_delay) begin
                vdp_ack = 1'b1;
                req_cnt = 0;
                e.wrt = vdp_wrt;
                e.adr = {6'b0, vdp_adr};
                e.dbo = vdp_dbo;
                log_q.push_back(e);
            end
        end else begin
            req_cnt = 0;
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // One Z80 I/O cycle: strobes low for 'hold' clocks, then idle long enough to re-arm the filter.
    task automatic bus_cycle(input logic [7:0] a, input logic [7:0] d, input bit is_rd,
                             input int hold, input int clr_at, output int c0);
        io_addr = a;
        cd_in   = d;
        @(posedge clk);
        #1;
        c0     = cyc;
        iorq_n = 1'b0;
        if (is_rd) rd_n = 1'b0;
        else       wr_n = 1'b0;
        for (int k = 1; k <= hold; k++) begin
            @(posedge clk);
            #1;
            ovf_clr = (k == clr_at - 1);
            if (is_rd && k == 2) begin
                chk("cd_oe_during_rd", cd_oe, 1);
                chk("cd_out_eq_dbi", cd_out, dbi_val);
            end
        end
        iorq_n  = 1'b1;
        rd_n    = 1'b1;
        wr_n    = 1'b1;
        ovf_clr = 1'b0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic wait_log(input int n, input int budget, input string name);
        int t;
        t = 0;
        while (log_q.size() < n && t < budget) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk(name, 32'(log_q.size() >= n), 1);
    endtask

    task automatic pulse_clr();
        @(posedge clk);
        #1 ovf_clr = 1'b1;
        @(posedge clk);
        #1 ovf_clr = 1'b0;
    endtask

    initial begin
        int c0, n0, r0;

        dtab[0] = '{8'h98, 0, 1, 0, 0};
        dtab[1] = '{8'h9B, 0, 0, 0, 1};
        dtab[2] = '{8'h9C, 0, 0, 1, 0};
        dtab[3] = '{8'h97, 0, 0, 1, 0};
        dtab[4] = '{8'h99, 1, 0, 1, 0};
        dtab[5] = '{8'h00, 0, 0, 1, 0};
        dtab[6] = '{8'h9A, 1, 1, 1, 0};

        wtab[0] = '{8'h99, 8'h12, 1, 8'd1};
        wtab[1] = '{8'h99, 8'h87, 1, 8'd1};
        wtab[2] = '{8'h98, 8'h5A, 1, 8'd0};
        wtab[3] = '{8'h9B, 8'hFF, 1, 8'd3};
        wtab[4] = '{8'h9C, 8'h33, 0, 8'd0};
        wtab[5] = '{8'h97, 8'h44, 0, 8'd0};
        wtab[6] = '{8'h9A, 8'h00, 1, 8'd2};

        rst = 1'b1; io_addr = 8'h00; cd_in = 8'h00; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        vdp_dbi = 8'h00; ovf_clr = 1'b0; vdp_ack = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_vdp_req", vdp_req, 0);
        chk("rst_vdp_wrt", vdp_wrt, 0);
        chk("rst_vdp_adr", vdp_adr, 0);
        chk("rst_vdp_dbo", vdp_dbo, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_cd_out", cd_out, 0);
        chk("rst_cd_oe", cd_oe, 0);
        chk("rst_cs_n", cs_n, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Combinational decode; each vector lasts one clock so the filter never accepts it.
        for (int i = 0; i < 7; i++) begin
            io_addr = dtab[i].addr;
            iorq_n  = dtab[i].iorq;
            rd_n    = dtab[i].rd;
            #2;
            chk($sformatf("decode_cs_n[%0d]", i), cs_n, dtab[i].exp_cs_n);
            chk($sformatf("decode_cd_oe[%0d]", i), cd_oe, dtab[i].exp_oe);
            @(posedge clk);
            #1;
            iorq_n = 1'b1;
            rd_n   = 1'b1;
            repeat (4) @(posedge clk);
            #1;
        end
        repeat (10) @(posedge clk);
        #1;
        chk("decode_no_req", req_rises, 0);

        // Single OUTs, each acked 5 clocks after the request.
        for (int i = 0; i < 7; i++) begin
            n0 = log_q.size();
            r0 = req_rises;
            bus_cycle(wtab[i].addr, wtab[i].data, 0, 8, -1, c0);
            if (i == 0) chk("first_req_latency", rise_cyc - c0, LAT);
            if (wtab[i].push) begin
                wait_log(n0 + 1, 40, $sformatf("wr_acked[%0d]", i));
                if (log_q.size() > n0) begin
                    chk($sformatf("wr_wrt[%0d]", i), log_q[n0].wrt, 1);
                    chk($sformatf("wr_adr[%0d]", i), log_q[n0].adr, wtab[i].adr);
                    chk($sformatf("wr_dbo[%0d]", i), log_q[n0].dbo, wtab[i].data);
                end
            end else begin
                repeat (20) @(posedge clk);
                #1;
                chk($sformatf("outside_no_req[%0d]", i), req_rises, r0);
            end
        end

        // Strobe one sample short of the filter length must be ignored.
        r0 = req_rises;
        n0 = log_q.size();
        bus_cycle(8'h99, 8'h55, 0, FILTER_LEN - 1, -1, c0);
        repeat (20) @(posedge clk);
        #1;
        chk("glitch_no_req", req_rises, r0);
        chk("glitch_no_log", log_q.size(), n0);

        // Fill the FIFO with acks held off; the fifth write is dropped even with ovf_clr at the drop edge.
        ack_en = 0;
        for (int j = 0; j < 4; j++) bus_cycle(8'h99, 8'hA0 + 8'(j), 0, 8, -1, c0);
        chk("ovf_not_yet", overflow, 0);
        bus_cycle(8'h99, 8'hA4, 0, 8, LAT, c0);
        chk("ovf_set_wins", overflow, 1);
        pulse_clr();
        #2;
        chk("ovf_cleared", overflow, 0);
        bus_cycle(8'h99, 8'hA5, 0, 8, -1, c0);
        chk("ovf_set_again", overflow, 1);
        chk("stall_req_held", vdp_req, 1);
        chk("stall_dbo_head", vdp_dbo, 8'hA0);
        n0 = log_q.size();
        ack_delay = 1;
        ack_en = 1;
        wait_log(n0 + 4, 60, "drain_four");
        for (int j = 0; j < 4; j++) begin
            if (log_q.size() > n0 + j) chk($sformatf("drain_dbo[%0d]", j), log_q[n0 + j].dbo, 8'hA0 + 8'(j));
        end
        chk("drain_idle_gap", last_gap, 1);
        repeat (20) @(posedge clk);
        #1;
        chk("drain_no_fifth", log_q.size(), n0 + 4);
        chk("ovf_sticky", overflow, 1);
        pulse_clr();
        #2;
        chk("ovf_clr_after_drain", overflow, 0);

        // Two queued writes followed by a read: the read must follow both write acks.
        ack_delay = 20;
        dbi_val = 8'hC3;
        vdp_dbi = dbi_val;
        n0 = log_q.size();
        bus_cycle(8'h99, 8'h11, 0, 8, -1, c0);
        bus_cycle(8'h99, 8'h22, 0, 8, -1, c0);
        bus_cycle(8'h98, 8'h00, 1, 8, -1, c0);
        chk("cd_oe_after_rd", cd_oe, 0);
        wait_log(n0 + 3, 120, "rd_after_writes");
        if (log_q.size() > n0 + 2) begin
            chk("order_w1_dbo", log_q[n0].dbo, 8'h11);
            chk("order_w2_dbo", log_q[n0 + 1].dbo, 8'h22);
            chk("order_w2_wrt", log_q[n0 + 1].wrt, 1);
            chk("rd_wrt", log_q[n0 + 2].wrt, 0);
            chk("rd_adr", log_q[n0 + 2].adr, 0);
        end

        // Reset while a request is outstanding with three entries queued.
        ack_en = 0;
        for (int j = 0; j < 3; j++) bus_cycle(8'h99, 8'h31 + 8'(j), 0, 8, -1, c0);
        chk("pre_rst_req", vdp_req, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_req", vdp_req, 0);
        chk("mid_rst_wrt", vdp_wrt, 0);
        chk("mid_rst_adr", vdp_adr, 0);
        chk("mid_rst_dbo", vdp_dbo, 0);
        r0 = req_rises;
        n0 = log_q.size();
        @(posedge clk);
        #1 rst = 1'b0;
        ack_delay = 2;
        ack_en = 1;
        repeat (40) @(posedge clk);
        #1;
        chk("post_rst_no_req", req_rises, r0);
        chk("post_rst_no_log", log_q.size(), n0);
        bus_cycle(8'h9A, 8'h77, 0, 8, -1, c0);
        wait_log(n0 + 1, 40, "post_rst_write");
        if (log_q.size() > n0) begin
            chk("post_rst_adr", log_q[n0].adr, 2);
            chk("post_rst_dbo", log_q[n0].dbo, 8'h77);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
